// File: rtl/seg7_pkg.sv
// seg7_pkg: shared active-low segment codes {g,f,e,d,c,b,a} for the seven-segment scanner
package seg7_pkg;
  typedef logic [6:0] seg_t;
  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: data/strobe inputs and multiplexed display outputs of the scanner
interface seg7_scan_if #(parameter int NUM_DIGITS = 4);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    upd;
  logic                    blank_lz;
  logic [6:0]              seg;
  logic                    dp;
  logic [NUM_DIGITS-1:0]   an;
  modport master (output digits_in, dp_in, upd, blank_lz, input seg, dp, an);
  modport slave  (input digits_in, dp_in, upd, blank_lz, output seg, dp, an);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: BCD to active-low segment code; codes 10-15 show a dash
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output seg_t       o_seg
);
  always_comb
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment scanner with shadow registers, slot blanking and leading-zero suppression
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 1000
)(
  input logic        clk,
  input logic        reset,
  seg7_scan_if.slave bus
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [3:0]            r_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] r_dpsh;
  seg_t                  r_seg;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_an;
  logic                  w_wrap;
  logic                  w_run;
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_an;
  seg_t                  w_dec;
  assign w_wrap = r_cnt == CW'(SCAN_DIV - 1);
  // w_lz[k]: digit k and every more-significant digit hold exactly zero
  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run   = w_run && (r_dig[k] == 4'd0);
      w_lz[k] = w_run;
    end
  end
  assign w_blank = bus.blank_lz && (r_idx != '0) && w_lz[r_idx];
  assign w_an    = (r_cnt < CW'(BLANK_CYC)) ? '1 : ~(NUM_DIGITS'(1) << r_idx);
  seg7_decode u_dec (.i_bcd(r_dig[r_idx]), .o_seg(w_dec));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_cnt  <= '0;
      r_idx  <= '0;
      r_dig  <= '{default: '0};
      r_dpsh <= '0;
      r_seg  <= SEG_BLANK;
      r_dp   <= 1'b1;
      r_an   <= '1;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) r_idx <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      if (bus.upd) begin
        for (int k = 0; k < NUM_DIGITS; k++) r_dig[k] <= bus.digits_in[4*k +: 4];
        r_dpsh <= bus.dp_in;
      end
      r_seg <= w_blank ? SEG_BLANK : w_dec;
      r_dp  <= ~r_dpsh[r_idx];
      r_an  <= w_an;
    end
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;
  assign bus.an  = r_an;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized self-checking bench against a slot/arithmetic display model
module tb_seg7_scan;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BC = 1;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   cyc;
  logic [15:0] m_sh;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [6:0]  seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                                7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};
  seg7_scan_if #(.NUM_DIGITS(ND)) bus ();
  seg7_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    checks++;
    if ($countones(~bus.an) > 1) begin
      errors++;
      $display("FAIL onecold an=%b has more than one enabled digit", bus.an);
    end
  end
  // Expected outputs after the next edge follow from elapsed cycles since reset and the shadow value
  task automatic tick();
    int c, s;
    logic [3:0] d;
    c = cyc % SD;
    s = (cyc / SD) % ND;
    d = m_sh[4*s +: 4];
    exp_an  = (c < BC) ? 4'hF : ~(4'b0001 << s);
    exp_seg = (s > 0 && bus.blank_lz && (m_sh >> (4*s)) == 16'd0) ? 7'h7F : seg_tab[d];
    exp_dp  = ~m_dp[s];
    @(posedge clk);
    if (bus.upd) begin
      m_sh = bus.digits_in;
      m_dp = bus.dp_in;
    end
    cyc++;
    #1;
  endtask
  task automatic model_reset();
    cyc  = 0;
    m_sh = '0;
    m_dp = '0;
  endtask
  task automatic test_reset();
    bus.upd = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
    reset = 1'b0;
    #12;
    checks += 3;
    if (bus.an !== 4'hF) begin errors++; $display("FAIL reset_an got=%b exp=1111", bus.an); end
    if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got=%b exp=1111111", bus.seg); end
    if (bus.dp !== 1'b1) begin errors++; $display("FAIL reset_dp got=%b exp=1", bus.dp); end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.an !== exp_an) begin errors++; $display("FAIL reset_seq_an cyc=%0d got=%b exp=%b", cyc, bus.an, exp_an); end
      if (exp_an != 4'hF) begin
        checks += 2;
        if (bus.seg !== exp_seg) begin errors++; $display("FAIL reset_seq_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, exp_seg); end
        if (bus.dp !== exp_dp) begin errors++; $display("FAIL reset_seq_dp cyc=%0d got=%b exp=%b", cyc, bus.dp, exp_dp); end
      end
    end
  endtask
  task automatic test_scan();
    bus.digits_in = 16'h1234; bus.dp_in = 4'b0101; bus.upd = 1'b1;
    tick();
    bus.upd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.an !== exp_an) begin errors++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, bus.an, exp_an); end
      if (exp_an != 4'hF) begin
        checks += 2;
        if (bus.seg !== exp_seg) begin errors++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, exp_seg); end
        if (bus.dp !== exp_dp) begin errors++; $display("FAIL scan_dp cyc=%0d got=%b exp=%b", cyc, bus.dp, exp_dp); end
      end
    end
  endtask
  task automatic test_hold();
    bus.digits_in = 16'h9876; bus.dp_in = 4'b1111;
    for (int i = 0; i < 33; i++) begin
      bus.upd = (i == 16);
      tick();
      checks++;
      if (bus.an !== exp_an) begin errors++; $display("FAIL hold_an cyc=%0d got=%b exp=%b", cyc, bus.an, exp_an); end
      if (exp_an != 4'hF) begin
        checks += 2;
        if (bus.seg !== exp_seg) begin errors++; $display("FAIL hold_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, exp_seg); end
        if (bus.dp !== exp_dp) begin errors++; $display("FAIL hold_dp cyc=%0d got=%b exp=%b", cyc, bus.dp, exp_dp); end
      end
    end
    bus.upd = 1'b0;
  endtask
  task automatic test_blank();
    logic [15:0] pat [3] = '{16'h0050, 16'h0050, 16'h00A0};
    logic        lz  [3] = '{1'b1, 1'b0, 1'b1};
    for (int p = 0; p < 3; p++) begin
      bus.digits_in = pat[p]; bus.dp_in = (p == 2) ? 4'b1010 : 4'b0000;
      bus.blank_lz = lz[p]; bus.upd = 1'b1;
      tick();
      bus.upd = 1'b0;
      for (int i = 0; i < 16; i++) begin
        tick();
        checks++;
        if (bus.an !== exp_an) begin errors++; $display("FAIL blank_an p=%0d cyc=%0d got=%b exp=%b", p, cyc, bus.an, exp_an); end
        if (exp_an != 4'hF) begin
          checks += 2;
          if (bus.seg !== exp_seg) begin errors++; $display("FAIL blank_seg p=%0d cyc=%0d got=%b exp=%b", p, cyc, bus.seg, exp_seg); end
          if (bus.dp !== exp_dp) begin errors++; $display("FAIL blank_dp p=%0d cyc=%0d got=%b exp=%b", p, cyc, bus.dp, exp_dp); end
        end
      end
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 320; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.digits_in = 16'($urandom);
        if ($urandom_range(0, 1) == 1) bus.digits_in[15:8] = 8'h00;
        bus.dp_in = 4'($urandom);
      end
      if ($urandom_range(0, 15) == 0) bus.blank_lz = ~bus.blank_lz;
      bus.upd = ($urandom_range(0, 5) == 0);
      tick();
      checks++;
      if (bus.an !== exp_an) begin errors++; $display("FAIL random_an cyc=%0d got=%b exp=%b", cyc, bus.an, exp_an); end
      if (exp_an != 4'hF) begin
        checks += 2;
        if (bus.seg !== exp_seg) begin errors++; $display("FAIL random_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, exp_seg); end
        if (bus.dp !== exp_dp) begin errors++; $display("FAIL random_dp cyc=%0d got=%b exp=%b", cyc, bus.dp, exp_dp); end
      end
    end
    bus.upd = 1'b0;
  endtask
  task automatic test_reset_mid();
    int n = 0;
    bus.digits_in = 16'h4321; bus.dp_in = 4'b0100; bus.blank_lz = 1'b0; bus.upd = 1'b1;
    tick();
    bus.upd = 1'b0;
    while (exp_an != 4'b1011 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (exp_an != 4'b1011 || bus.an !== 4'b1011) begin
      errors++;
      $display("FAIL midreset_reach got=%b exp=1011 after %0d cycles", bus.an, n);
    end
    #2;
    reset = 1'b0;
    #1;
    checks += 3;
    if (bus.an !== 4'hF) begin errors++; $display("FAIL midreset_an got=%b exp=1111", bus.an); end
    if (bus.seg !== 7'h7F) begin errors++; $display("FAIL midreset_seg got=%b exp=1111111", bus.seg); end
    if (bus.dp !== 1'b1) begin errors++; $display("FAIL midreset_dp got=%b exp=1", bus.dp); end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      bus.upd = (i == 9);
      tick();
      checks++;
      if (bus.an !== exp_an) begin errors++; $display("FAIL midreset_seq_an cyc=%0d got=%b exp=%b", cyc, bus.an, exp_an); end
      if (exp_an != 4'hF) begin
        checks += 2;
        if (bus.seg !== exp_seg) begin errors++; $display("FAIL midreset_seq_seg cyc=%0d got=%b exp=%b", cyc, bus.seg, exp_seg); end
        if (bus.dp !== exp_dp) begin errors++; $display("FAIL midreset_seq_dp cyc=%0d got=%b exp=%b", cyc, bus.dp, exp_dp); end
      end
    end
    bus.upd = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    #1;
    test_reset();
    test_scan();
    test_hold();
    test_blank();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
